// File: rtl/packet_tx_port_pkg.sv
// Shared link configuration: packet format, credit width, tx states.
// Imported by the packet_tx_port slice.
package packet_tx_port_pkg;

  localparam int INPUT_QUEUE_DEPTH = 8;
  localparam int CREDIT_W = 4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [23:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLOCKED
  } tx_state_t;

  // a - b, clamped at zero
  function automatic logic [4:0] clamp_sub(
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (a > b) ? (a - b) : 5'd0;
  endfunction

endpackage

// File: rtl/packet_tx_port_credit.sv
// Credit tracker: launch history, effective credit, credit error.
// Ports: clk, reset_n, ce, launch, i_credit -> can_send, credit_err.
module tx_credit_tracker
  import packet_tx_port_pkg::*;
#(
  parameter int MAX_CREDIT = INPUT_QUEUE_DEPTH,
  parameter int CREDIT_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                launch,
  input  logic [CREDIT_W-1:0] i_credit,
  output logic                can_send,
  output logic                credit_err
);

  logic [CREDIT_LAT-1:0] hist;
  logic [CREDIT_LAT-1:0] hist_nx;
  logic [4:0]            inflight;
  logic [4:0]            credit_ok;
  logic [4:0]            eff;
  logic                  bad;

  // launches not yet visible in i_credit
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CREDIT_LAT; i++)
      inflight = inflight + 5'(hist[i]);
  end

  always_comb begin
    hist_nx = '0;
    hist_nx[0] = launch;
    for (int i = 1; i < CREDIT_LAT; i++)
      hist_nx[i] = hist[i-1];
  end

  assign bad       = {1'b0, i_credit} > 5'(MAX_CREDIT);
  assign credit_ok = bad ? 5'd0 : {1'b0, i_credit};
  assign eff       = clamp_sub(credit_ok, inflight);
  assign can_send  = (eff != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist       <= '0;
      credit_err <= 1'b0;
    end else if (ce) begin
      hist <= hist_nx;
      if (bad)
        credit_err <= 1'b1;
    end
  end

endmodule

// File: rtl/packet_tx_port.sv
// Credit-based link transmitter: local queue, launch control, FSM.
// Ports: clk, reset_n, ce, i_data/i_data_val/o_en (local side),
//   o_data/o_data_val/i_credit (link), o_stall_cnt, o_credit_err.
module packet_tx_port
  import packet_tx_port_pkg::*;
#(
  parameter int TX_DEPTH   = 2,
  parameter int MAX_CREDIT = INPUT_QUEUE_DEPTH,
  parameter int CREDIT_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  packet_t             i_data,
  input  logic                i_data_val,
  output logic                o_en,
  output packet_t             o_data,
  output logic                o_data_val,
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [15:0]         o_stall_cnt,
  output logic                o_credit_err
);

  localparam int PTR_W =
    (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CNT_W = $clog2(TX_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(TX_DEPTH - 1);

  packet_t          mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  tx_state_t        state;
  logic             can_send;
  logic             accept;
  logic             launch;
  logic             has_pkt;

  function automatic logic [PTR_W-1:0] bump(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_en    = (count < CNT_W'(TX_DEPTH));
  assign has_pkt = (count != '0);
  assign accept  = ce & i_data_val & o_en;
  assign launch  = ce & has_pkt & can_send;

  always_comb begin
    count_nx = count;
    unique case ({accept, launch})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  tx_credit_tracker #(
    .MAX_CREDIT (MAX_CREDIT),
    .CREDIT_LAT (CREDIT_LAT)
  ) u_credit (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .launch     (launch),
    .i_credit   (i_credit),
    .can_send   (can_send),
    .credit_err (o_credit_err)
  );

  // payload storage needs no reset
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_data      <= '0;
      o_data_val  <= 1'b0;
      o_stall_cnt <= '0;
      state       <= IDLE;
    end else if (ce) begin
      count <= count_nx;
      if (accept)
        wr_ptr <= bump(wr_ptr);
      if (launch) begin
        o_data     <= mem[rd_ptr];
        o_data_val <= 1'b1;
        rd_ptr     <= bump(rd_ptr);
      end else begin
        o_data_val <= 1'b0;
      end
      if (state == BLOCKED &&
          o_stall_cnt != 16'hFFFF)
        o_stall_cnt <= o_stall_cnt + 16'd1;
      // post-edge occupancy, current credit
      unique case (1'b1)
        (count_nx == '0):
          state <= IDLE;
        (count_nx != '0) && can_send:
          state <= ACTIVE;
        (count_nx != '0) && !can_send:
          state <= BLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx_port.sv
// Bench for packet_tx_port: random traffic vs a queue-level model.
// Downstream queue is modelled to supply i_credit.
module tb_packet_tx_port;
  import packet_tx_port_pkg::*;

  localparam int TX_DEPTH   = 2;
  localparam int MAX_CREDIT = 8;
  localparam int CREDIT_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  packet_t     i_data = '0;
  logic        i_data_val = 1'b0;
  logic        o_en;
  packet_t     o_data;
  logic        o_data_val;
  logic [3:0]  i_credit = '0;
  logic [15:0] o_stall_cnt;
  logic        o_credit_err;

  always #5 clk = ~clk;

  packet_tx_port #(
    .TX_DEPTH   (TX_DEPTH),
    .MAX_CREDIT (MAX_CREDIT),
    .CREDIT_LAT (CREDIT_LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .i_data       (i_data),
    .i_data_val   (i_data_val),
    .o_en         (o_en),
    .o_data       (o_data),
    .o_data_val   (o_data_val),
    .i_credit     (i_credit),
    .o_stall_cnt  (o_stall_cnt),
    .o_credit_err (o_credit_err)
  );

  int        tests = 0;
  int        fails = 0;
  packet_t   mq[$];
  bit        recent[$];
  bit        m_val;
  packet_t   m_data;
  int        m_stall;
  bit        m_err;
  tx_state_t m_state;
  int        ds_occ;
  bit        drain_en;
  bit        use_ds;
  int        pulses;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one clock: drive, predict, clock, compare
  task automatic step(input bit rn, input bit c,
                      input bit v, input int cr);
    packet_t    d;
    logic [3:0] cr4;
    bit         oen, launch, pv;
    int         cred, infl, eff;
    d   = packet_t'($urandom);
    cr4 = use_ds ? 4'(MAX_CREDIT - ds_occ) : 4'(cr);
    reset_n    = rn;
    ce         = c;
    i_data_val = v;
    i_data     = d;
    i_credit   = cr4;
    pv  = o_data_val;
    oen = mq.size() < TX_DEPTH;
    if (!rn) begin
      mq.delete();
      recent.delete();
      repeat (CREDIT_LAT) recent.push_back(1'b0);
      m_val = 0; m_data = '0; m_stall = 0;
      m_err = 0; m_state = IDLE; ds_occ = 0;
    end else if (c) begin
      cred = (cr4 > MAX_CREDIT) ? 0 : int'(cr4);
      if (cr4 > MAX_CREDIT) m_err = 1;
      infl = 0;
      foreach (recent[i]) infl += int'(recent[i]);
      eff = (cred > infl) ? cred - infl : 0;
      launch = (mq.size() > 0) && (eff >= 1);
      if (m_state == BLOCKED && m_stall < 65535)
        m_stall++;
      if (launch) begin
        m_data = mq.pop_front();
        m_val  = 1;
      end else begin
        m_val = 0;
      end
      if (v && oen) mq.push_back(d);
      void'(recent.pop_front());
      recent.push_back(launch);
      if (mq.size() == 0)  m_state = IDLE;
      else if (eff >= 1)   m_state = ACTIVE;
      else                 m_state = BLOCKED;
      if (use_ds)
        ds_occ = ds_occ + int'(pv)
               - ((drain_en && ds_occ > 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    if (o_data_val === 1'b1) pulses++;
    chk("data_val", o_data_val, m_val);
    chk("data", o_data, m_data);
    chk("stall_cnt", o_stall_cnt, 16'(m_stall));
    chk("credit_err", o_credit_err, m_err);
    chk("en", o_en, mq.size() < TX_DEPTH);
    chk("state", dut.state, m_state);
    if (use_ds)
      chk("ds_overflow", ds_occ <= MAX_CREDIT, 1);
  endtask

  initial begin
    int offered;
    use_ds = 1; drain_en = 1; pulses = 0;
    mq.delete();
    recent.delete();
    repeat (CREDIT_LAT) recent.push_back(1'b0);
    m_state = IDLE;
    #2;
    // reset
    step(0, 1, 0, 8);
    step(0, 1, 1, 8);
    chk("reset_en", o_en, 1);
    // single packet
    pulses = 0;
    step(1, 1, 1, 0);
    repeat (4) step(1, 1, 0, 0);
    chk("single_pulses", pulses, 1);
    // back-to-back stream of 10
    pulses = 0;
    repeat (10) step(1, 1, 1, 0);
    repeat (6) step(1, 1, 0, 0);
    chk("stream_pulses", pulses, 10);
    chk("stream_stall", o_stall_cnt, 0);
    // stale credit, then blocked
    use_ds = 0;
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    repeat (4) step(1, 1, 1, 0);
    chk("blocked_en", o_en, 0);
    step(1, 1, 0, 2);
    step(1, 1, 0, 1);
    repeat (6) step(1, 1, 0, 8);
    // no drain downstream: 8 launches max
    use_ds = 1; drain_en = 0; ds_occ = 0;
    pulses = 0; offered = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 1, offered < 12, 0);
      offered++;
    end
    chk("nodrain_pulses", pulses, 8);
    chk("nodrain_en", o_en, 0);
    drain_en = 1;
    repeat (20) step(1, 1, 0, 0);
    // invalid credit
    use_ds = 0;
    step(1, 1, 1, 0);
    pulses = 0;
    step(1, 1, 0, 15);
    chk("badcred_nolaunch", pulses, 0);
    step(1, 1, 0, 8);
    step(1, 1, 0, 8);
    chk("err_sticky", o_credit_err, 1);
    // random traffic with ce gaps
    use_ds = 1; ds_occ = 0;
    repeat (4) step(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      drain_en = ($urandom % 3) != 0;
      step(1, ($urandom % 4) != 0,
           ($urandom % 3) != 0, 0);
    end
    // ce low mid-stream holds everything
    step(1, 1, 1, 0);
    repeat (3) step(1, 0, 1, 0);
    // reset with queue full and one in flight
    use_ds = 0;
    repeat (3) step(1, 1, 0, 8);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    step(0, 1, 1, 8);
    chk("rst_mid_val", o_data_val, 0);
    chk("rst_mid_en", o_en, 1);
    use_ds = 1; ds_occ = 0; drain_en = 1;
    repeat (6) step(1, 1, 1, 0);
    repeat (4) step(1, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
